// File: rtl/tty_uart_tx_if.sv
// TTY write-port bundle between the MCU bus decode (master) and the UART transmitter (slave).
// FIFO_AW must match the FIFO_AW of the attached tty_uart_tx.
interface tty_uart_tx_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic [6:0]       tty_data_i;
    logic             tty_we_i;
    logic             busy_o;
    logic             full_o;
    logic             overflow_o;
    logic [FIFO_AW:0] level_o;

    modport master (
        output tty_data_i, tty_we_i,
        input  busy_o, full_o, overflow_o, level_o
    );

    modport slave (
        input  tty_data_i, tty_we_i,
        output busy_o, full_o, overflow_o, level_o
    );
endinterface

// File: rtl/tty_uart_tx.sv
// TTY character FIFO feeding an 8N1 UART transmitter (8E1 when TTY_UART_PARITY_EN is defined).
// Idle line is high; back-to-back frames leave no idle gap when the FIFO is non-empty.
module tty_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic          clk_i,
    input  logic          rst_in,
    tty_uart_tx_if.slave  bus,
    output logic          tx_o
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef TTY_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_baud, w_baud_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_ovf;
    logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic [FIFO_AW:0] w_level;
    logic [6:0]       r_mem [DEPTH];
    logic [6:0]       w_head;
    logic             w_full, w_push, w_pop, w_load, w_bit_end;
`ifdef TTY_UART_PARITY_EN
    logic             r_par, w_par_nxt;
`endif

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == (FIFO_AW + 1)'(DEPTH));
    assign w_head    = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_pop     = w_load;
    assign w_push    = bus.tty_we_i & (~w_full | w_pop);
    assign w_wr_nxt  = r_wr_ptr + (FIFO_AW + 1)'(w_push);
    assign w_rd_nxt  = r_rd_ptr + (FIFO_AW + 1)'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
`ifdef TTY_UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_level != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef TTY_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef TTY_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (w_level != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_shift_nxt = {1'b0, w_head};
`ifdef TTY_UART_PARITY_EN
            w_par_nxt   = ^w_head;
`endif
        end

        // Line level is registered from the next state so tx_o changes on the same edge as the FSM.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef TTY_UART_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) | (w_wr_nxt != w_rd_nxt);
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
`ifdef TTY_UART_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            if (bus.tty_we_i && w_full && !w_pop)
                r_ovf <= 1'b1;
`ifdef TTY_UART_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= bus.tty_data_i;
    end

    assign tx_o           = r_tx;
    assign bus.busy_o     = r_busy;
    assign bus.full_o     = w_full;
    assign bus.overflow_o = r_ovf;
    assign bus.level_o    = w_level;
endmodule

// File: tb/tb_tty_uart_tx.sv
// Self-checking bench for tty_uart_tx: frame-position model compared every cycle,
// plus literal checks of the directed scenarios and randomized traffic.
module tb_tty_uart_tx;
    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef TTY_UART_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    int   checks = 0;
    int   errors = 0;

    tty_uart_tx_if #(.FIFO_AW(AW)) bus ();

    tty_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus.slave),
        .tx_o   (tx)
    );

    always #5 clk = ~clk;

    // Model: a queue of pending characters and the position (in clocks) inside the current frame.
    logic [6:0] q[$];
    bit         m_active;
    int         m_t;
    logic [6:0] m_cur;
    bit         m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        bit pop, push;
        if (!rst_n) begin
            q.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
        end else begin
            pop  = (q.size() > 0) && (!m_active || m_t == FRAME - 1);
            push = 0;
            if (bus.tty_we_i) begin
                if (q.size() < DEPTH || pop) push = 1;
                else m_ovf = 1;
            end
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 0;
            end
            if (pop) begin
                m_cur    = q.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (push) q.push_back(bus.tty_data_i);
        end
    end

    function automatic int exp_tx();
        int k;
        logic [7:0] fr;
        if (!m_active) return 1;
        k  = m_t / CPB;
        fr = {1'b0, m_cur};
        if (k == 0) return 0;
        if (k <= 8) return int'(fr[k-1]);
`ifdef TTY_UART_PARITY_EN
        if (k == 9) return int'(^fr);
`endif
        return 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx",       int'(tx),             exp_tx());
            chk("level",    int'(bus.level_o),    q.size());
            chk("full",     int'(bus.full_o),     int'(q.size() == DEPTH));
            chk("busy",     int'(bus.busy_o),     int'(m_active || q.size() != 0));
            chk("overflow", int'(bus.overflow_o), int'(m_ovf));
        end
    end

    logic       txs[256];
    int         busycnt;
    int         falls;
    logic [6:0] chars[8];

    task automatic do_reset();
        @(negedge clk);
        bus.tty_we_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Push chars[0..n-1] on consecutive edges; returns at the negedge after the last push.
    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.tty_we_i   = 1'b1;
            bus.tty_data_i = chars[i];
        end
        @(negedge clk);
        bus.tty_we_i = 1'b0;
    endtask

    // Sample n negedges starting with the current one.
    task automatic run_watch(input int n);
        logic prev;
        prev    = 1'b1;
        busycnt = 0;
        falls   = 0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            txs[i] = tx;
            busycnt += int'(bus.busy_o);
            if (prev && !tx) falls++;
            prev = tx;
        end
    endtask

    initial begin
        logic [9:0] bits41;
        int p;
        bus.tty_we_i   = 1'b0;
        bus.tty_data_i = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_tx",    int'(tx),             1);
        chk("rst_busy",  int'(bus.busy_o),     0);
        chk("rst_full",  int'(bus.full_o),     0);
        chk("rst_ovf",   int'(bus.overflow_o), 0);
        chk("rst_level", int'(bus.level_o),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single 0x41 frame, start + LSB-first bits
        chars[0] = 7'h41;
        push_seq(1);
        run_watch(FRAME + 10);
        bits41 = 10'b1_0100_0001_0;
        for (int k = 0; k < 9; k++) chk("t1_bit", int'(txs[4*k+3]), int'(bits41[k]));
        chk("t1_stop", int'(txs[FRAME - 1]), 1);
        chk("t1_busy_cycles", busycnt, FRAME + 1);
        chk("t1_level", int'(bus.level_o), 0);

        // 2: two frames back to back
        chars[0] = 7'h48; chars[1] = 7'h69;
        push_seq(2);
        run_watch(2 * FRAME + 10);
        chk("t2_last_stop", int'(txs[FRAME - 1]), 1);
        chk("t2_start2", int'(txs[FRAME]), 0);
        chk("t2_busy_cycles", busycnt, 2 * FRAME);

        // 3: six pushes from empty, sixth dropped
        do_reset();
        for (int i = 0; i < 6; i++) chars[i] = 7'h00;
        push_seq(6);
        chk("t3_full",  int'(bus.full_o),     1);
        chk("t3_level", int'(bus.level_o),    4);
        chk("t3_ovf",   int'(bus.overflow_o), 1);
        run_watch(5 * FRAME + 20);
        chk("t3_frames", falls, 5);
        chk("t3_ovf_sticky", int'(bus.overflow_o), 1);

        // 4: push into full FIFO on the STOP->START pop edge
        do_reset();
        for (int i = 0; i < 5; i++) chars[i] = 7'(8'h50 + i);
        push_seq(5);
        repeat (FRAME - 4) @(negedge clk);
        bus.tty_we_i = 1'b1; bus.tty_data_i = 7'h55;
        chk("t4_full_before", int'(bus.full_o), 1);
        @(negedge clk);
        bus.tty_we_i = 1'b0;
        chk("t4_level", int'(bus.level_o),    4);
        chk("t4_ovf",   int'(bus.overflow_o), 0);
        repeat (6 * FRAME) @(negedge clk);

        // 5: async reset during DATA bit 3
        do_reset();
        chars[0] = 7'h52; chars[1] = 7'h21; chars[2] = 7'h33;
        push_seq(3);
        repeat (16) @(negedge clk);
        chk("t5_bit3_low", int'(tx), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_tx",    int'(tx),            1);
        chk("t5_level", int'(bus.level_o),   0);
        chk("t5_busy",  int'(bus.busy_o),    0);
        @(negedge clk);
        rst_n = 1'b1;
        run_watch(2 * FRAME);
        chk("t5_no_frame", falls, 0);
        chk("t5_idle_busy", busycnt, 0);

`ifdef TTY_UART_PARITY_EN
        // 6: even parity bit
        chars[0] = 7'h07;
        push_seq(1);
        run_watch(FRAME + 10);
        chk("t6_par07", int'(txs[4*9+3]), 1);
        chk("t6_stop07", int'(txs[4*10+3]), 1);
        chk("t6_busy", busycnt, 45);
        chars[0] = 7'h03;
        push_seq(1);
        run_watch(FRAME + 10);
        chk("t6_par03", int'(txs[4*9+3]), 0);
`endif

        // randomized traffic at several push densities
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            p = (blk == 0) ? 2 : (blk == 1) ? 5 : (blk == 2) ? 30 : 90;
            for (int c = 0; c < 1200; c++) begin
                @(negedge clk);
                bus.tty_we_i   = ($urandom_range(0, 99) < p);
                bus.tty_data_i = 7'($urandom);
            end
        end
        @(negedge clk);
        bus.tty_we_i = 1'b0;
        repeat (6 * FRAME) @(negedge clk);
        chk("final_level", int'(bus.level_o), 0);
        chk("final_busy",  int'(bus.busy_o),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
